// File: rtl/status_value_drain.sv
// rtl/status_value_drain.sv - read-side drain for status_value_vector with skid buffer, flush and delivery counter
//
// Ports:
//   clk_i         clock
//   rsn_i         asynchronous active-low reset
//   vec_valid_i   vector holds at least one entry
//   vec_value_i   vector head entry (combinational from the vector)
//   vec_pull_o    remove the vector head at the next edge
//   out_valid_o   out_value_o holds a valid entry
//   out_value_o   oldest buffered entry
//   out_ready_i   consumer accepts out_value_o this cycle
//   flush_i       request to discard the buffer and drain the vector
//   flush_done_o  one-cycle pulse when a flush completes
//   busy_o        flush in progress
//   drain_count_o entries delivered downstream (wraps)
module status_value_drain #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 vec_valid_i,
  input  logic [WIDTH-1:0]     vec_value_i,
  output logic                 vec_pull_o,
  output logic                 out_valid_o,
  output logic [WIDTH-1:0]     out_value_o,
  input  logic                 out_ready_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] drain_count_o
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t               state, state_nxt;
  logic [1:0]           count, count_nxt;
  logic                 rd_ptr, rd_ptr_nxt;
  logic                 wr_ptr, wr_ptr_nxt;
  logic [WIDTH-1:0]     storage [2];
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 done_q, done_nxt;
  logic                 pull;
  logic                 pop;
  logic                 capture;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    pull       = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_RUN: begin
        // Pull depends only on registered occupancy, never on out_ready_i,
        // so the consumer's ready has no combinational path to the vector.
        pull    = vec_valid_i && (count != 2'd2) && !flush_i;
        pop     = (count != 2'd0) && out_ready_i && !flush_i;
        capture = pull;
        if (flush_i) begin
          state_nxt  = ST_FLUSH;
          count_nxt  = 2'd0;
          rd_ptr_nxt = 1'b0;
          wr_ptr_nxt = 1'b0;
        end else begin
          if (pull) wr_ptr_nxt = ~wr_ptr;
          if (pop) begin
            rd_ptr_nxt = ~rd_ptr;
            cnt_nxt    = cnt + 1'b1;
          end
          count_nxt = count + {1'b0, pull} - {1'b0, pop};
        end
      end
      ST_FLUSH: begin
        // Discard everything the vector offers; the first empty cycle ends it.
        pull = vec_valid_i;
        if (!vec_valid_i) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state      <= ST_RUN;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= '0;
      done_q     <= 1'b0;
      storage[0] <= '0;
      storage[1] <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
      if (capture) storage[wr_ptr] <= vec_value_i;
    end
  end

  // Gating with rsn_i keeps the vector untouched while reset is held.
  assign vec_pull_o    = pull && rsn_i;
  assign out_valid_o   = (count != 2'd0);
  assign out_value_o   = storage[rd_ptr];
  assign busy_o        = (state == ST_FLUSH);
  assign flush_done_o  = done_q;
  assign drain_count_o = cnt;

endmodule

// File: tb/tb_status_value_drain.sv
// tb/tb_status_value_drain.sv - self-checking bench for status_value_drain
module tb_status_value_drain;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rsn;
  logic          vec_valid;
  logic [W-1:0]  vec_value;
  logic          vec_pull;
  logic          out_valid;
  logic [W-1:0]  out_value;
  logic          out_ready;
  logic          flush;
  logic          flush_done;
  logic          busy;
  logic [CW-1:0] drain_count;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] vq[$];
  logic [W-1:0] mbuf[$];
  bit           m_flushing;
  bit           m_done;
  int           mcnt;
  int           n_pulls;
  int           n_done;

  status_value_drain #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .vec_valid_i(vec_valid), .vec_value_i(vec_value), .vec_pull_o(vec_pull),
    .out_valid_o(out_valid), .out_value_o(out_value), .out_ready_i(out_ready),
    .flush_i(flush), .flush_done_o(flush_done), .busy_o(busy),
    .drain_count_o(drain_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mbuf.delete();
    m_flushing = 1'b0;
    m_done     = 1'b0;
    mcnt       = 0;
  endtask

  task automatic cycle();
    bit          e_pull;
    bit          e_valid;
    logic        act_pull;
    logic [W-1:0] head;
    vec_valid = (vq.size() != 0);
    head      = (vq.size() != 0) ? vq[0] : '0;
    vec_value = head;
    #1;
    e_pull  = m_flushing ? (vq.size() != 0) : (vq.size() != 0 && mbuf.size() < 2 && !flush);
    e_valid = !m_flushing && (mbuf.size() != 0);
    chk("pull", vec_pull, e_pull);
    chk("out_valid", out_valid, e_valid);
    if (e_valid) chk("out_value", out_value, mbuf[0]);
    chk("busy", busy, m_flushing);
    chk("flush_done", flush_done, m_done);
    chk("drain_count", drain_count, mcnt % 16);
    act_pull = vec_pull;
    if (act_pull === 1'b1) n_pulls++;
    if (flush_done === 1'b1) n_done++;
    @(posedge clk);
    m_done = 1'b0;
    if (m_flushing) begin
      if (vq.size() == 0) begin
        m_flushing = 1'b0;
        m_done     = 1'b1;
      end
    end else if (flush) begin
      mbuf.delete();
      m_flushing = 1'b1;
    end else begin
      if (e_valid && out_ready) begin
        void'(mbuf.pop_front());
        mcnt++;
      end
      if (e_pull) mbuf.push_back(head);
    end
    if (act_pull === 1'b1 && vq.size() != 0) void'(vq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rsn       = 1'b0;
    vec_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    rsn = 1'b1;
  endtask

  initial begin
    rsn       = 1'b0;
    vec_valid = 1'b0;
    vec_value = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_pull", vec_pull, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_count", drain_count, 0);
    rsn = 1'b1;
    repeat (10) cycle();

    // Streaming 1..10 with the consumer always ready.
    vq.delete();
    for (int i = 1; i <= 10; i++) vq.push_back(W'(i));
    out_ready = 1'b1;
    n_pulls   = 0;
    repeat (10) cycle();
    chk("stream_consecutive_pulls", n_pulls, 10);
    repeat (4) cycle();
    chk("stream_count", drain_count, 10);

    // Backpressure: only two entries are taken while the consumer stalls.
    do_reset();
    vq.delete();
    for (int i = 1; i <= 5; i++) vq.push_back(W'(i));
    n_pulls = 0;
    repeat (6) cycle();
    chk("bp_pulls", n_pulls, 2);
    chk("bp_vector_left", vq.size(), 3);
    chk("bp_head_held", out_value, 1);
    out_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_count", drain_count, 5);
    chk("bp_vector_empty", vq.size(), 0);

    // Flush with a full buffer and six entries left in the vector.
    do_reset();
    vq.delete();
    for (int i = 1; i <= 8; i++) vq.push_back(W'(i));
    repeat (3) cycle();
    n_pulls = 0;
    n_done  = 0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    chk("flush_discards", n_pulls, 6);
    chk("flush_done_pulses", n_done, 1);
    chk("flush_vector_empty", vq.size(), 0);
    chk("flush_count", drain_count, 0);

    // Flush collides with a pop: the flush wins.
    do_reset();
    vq.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) vq.push_back(W'(i));
    repeat (5) cycle();
    out_ready = 1'b0;
    vq.push_back(4'd7);
    vq.push_back(4'd8);
    repeat (2) cycle();
    chk("coll_valid_before", out_valid, 1);
    out_ready = 1'b1;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    chk("coll_count_after", drain_count, 3);
    repeat (5) cycle();
    chk("coll_count_settled", drain_count, 3);

    // Counter wrap after 17 deliveries, then asynchronous reset mid-stream.
    do_reset();
    vq.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) vq.push_back(W'($urandom_range(0, 15)));
    repeat (20) cycle();
    chk("wrap_count", drain_count, 1);
    for (int i = 0; i < 6; i++) vq.push_back(W'($urandom_range(1, 15)));
    repeat (2) cycle();
    vec_valid = 1'b1;
    vec_value = vq[0];
    #2;
    rsn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_value", out_value, 0);
    chk("arst_pull", vec_pull, 0);
    chk("arst_count", drain_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", flush_done, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rsn = 1'b1;
    repeat (10) cycle();
    chk("arst_resume_empty", vq.size(), 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && vq.size() < 12) vq.push_back(W'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (30) cycle();
    chk("rand_vector_empty", vq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/status_value_drain.md
Name: status_value_drain

Overview:
- Read-side companion to status_value_vector. Drives the vector's pull input from the vector's head value and valid flag.
- Delivers each entry in order to a downstream consumer over a valid/ready handshake.
- A 2-entry skid buffer lets it sustain one pull per cycle without a combinational ready path from the consumer to the vector.
- Adds a flush mode that pulls and discards every pending entry, plus a running delivered-entry counter.

Parameters:
- WIDTH, 4: entry value width; must match the attached vector's WIDTH.
- CNT_WIDTH, 16: width of the delivered-entry counter.

Ports:
- clk_i  in  1  clock; one clock domain.
- rsn_i  in  1  reset, asynchronous, active-low.
- vec_valid_i  in  1  vector holds at least one entry (vector valid_o).
- vec_value_i  in  WIDTH  vector head entry, combinational (vector value_o).
- vec_pull_o  out  1  pull the head entry this cycle (to vector pull_i).
- out_valid_o  out  1  out_value_o holds a valid entry.
- out_value_o  out  WIDTH  oldest buffered entry.
- out_ready_i  in  1  consumer accepts out_value_o this cycle.
- flush_i  in  1  single-cycle request to discard buffer and drain the vector.
- flush_done_o  out  1  single-cycle pulse when a flush completes.
- busy_o  out  1  flush in progress.
- drain_count_o  out  CNT_WIDTH  count of entries delivered downstream.

Behaviour:
- Reset (rsn_i low, async): state=RUN; buffer count=0; rd/wr pointers=0; entry storage=0. Outputs: out_valid_o=0, out_value_o=0, vec_pull_o=0, flush_done_o=0, busy_o=0, drain_count_o=0.
- Reset mid-operation discards buffered entries. Entries already pulled are lost; entries not yet pulled stay in the vector.
- Vector contract: a pull asserted at edge N removes the head. The new head and valid are visible after edge N.
- Buffer: 2 entries, circular, 1-bit rd/wr pointers, count 0..2. out_valid_o = (count != 0). out_value_o = storage[rd_ptr].
- RUN, pull: vec_pull_o = vec_valid_i && (count < 2) && !flush_i. This is combinational from registered state and vec_valid_i only; it never depends on out_ready_i.
- RUN, capture: on a pull, vec_value_i is written to storage[wr_ptr] at the clock edge and wr_ptr toggles.
- RUN, pop: when out_valid_o && out_ready_i && !flush_i, rd_ptr toggles and drain_count_o increments. drain_count_o wraps modulo 2^CNT_WIDTH with no saturation.
- Simultaneous pull and pop: count unchanged, so throughput is 1 entry/cycle at count==1.
- At count==2 there is no pull; a pop that cycle leaves count=1 and pulling resumes next cycle.
- Latency: vec_valid_i rising with count==0 gives a pull that cycle and out_valid_o=1 the next cycle (1 cycle).
- out_valid_o / out_value_o are stable while out_valid_o && !out_ready_i (hold rule), except during a flush.
- RUN to FLUSH: when flush_i=1 in RUN, the next edge sets count=0 and rd/wr pointers=0, moves to FLUSH and sets busy_o=1.
  - No pop or count increment occurs that cycle, even if out_ready_i=1: flush wins.
  - No pull occurs that cycle.
- FLUSH: vec_pull_o = vec_valid_i; pulled values are discarded. out_valid_o=0. drain_count_o is unchanged.
- FLUSH exit: the first cycle in FLUSH with vec_valid_i=0 leads to RUN at the next edge, with flush_done_o=1 for exactly that one cycle and busy_o=0.
- Flush of an empty vector and empty buffer: FLUSH lasts 1 cycle, then flush_done_o pulses.
- flush_i while in FLUSH is ignored; it neither extends the flush nor produces a second done pulse.
- If the vector is pushed continuously during a flush, FLUSH persists until a cycle with vec_valid_i=0; there is no timeout.
- The vector's set_i (rewrite of its last entry) is outside this block. An entry already pulled into the buffer is not updated.

Test Plan:
- Reset/idle: rsn_i low for 4 cycles, vec_valid_i=0, then release. Required: all outputs 0, vec_pull_o=0 for 10 cycles.
- Streaming: vector pushed with 10 entries valued 1..10, out_ready_i=1 throughout. Required: vec_pull_o high for 10 consecutive cycles; out_value_o=1..10 in order, one per cycle; first out_valid_o 1 cycle after the first pull; drain_count_o=10.
- Backpressure: 5 entries valued 1..5 with out_ready_i=0. Required: exactly 2 pulls; count=2; out_value_o held at 1; vector retains 3. Then out_ready_i=1: values 1..5 delivered in order with none lost or duplicated; drain_count_o=5.
- Flush: 8 entries, out_ready_i=0, pulse flush_i. Required: out_valid_o=0 next cycle; busy_o high; 6 discard pulls; flush_done_o pulses once; vector empty; drain_count_o unchanged at 0.
- Flush vs pop collision: flush_i=1 in the same cycle as out_valid_o=1, out_ready_i=1 with drain_count_o=3. Required: drain_count_o stays 3 and no entry is delivered.
- Counter wrap and async reset: CNT_WIDTH=4, 17 entries delivered. Required: drain_count_o=1. Then assert rsn_i mid-stream between clock edges: outputs go to 0 immediately, without waiting for a clock edge.
